// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: opcodes, funct3 codes, FSM states and access sizing shared by the memory controller
package mem_ctrl_pkg;
  localparam logic [6:0] LD_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;
  localparam int FETCH_BYTES_DEF = 4;
  typedef enum logic [2:0] {IDLE, LOAD, STORE, FETCH, DONE} state_t;
  function automatic logic [2:0] width_of(input logic [2:0] op);
    return op[1:0] == 2'b00 ? 3'd1 : op[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend: sign/zero-extends an assembled load word according to funct3
module mem_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] data
);
  assign data = op == F3_B  ? {{24{raw[7]}}, raw[7:0]} :
                op == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
                op == F3_BU ? {24'd0, raw[7:0]} :
                op == F3_HU ? {16'd0, raw[15:0]} : raw;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises one LSB load/store or one instruction fetch onto the byte-wide RAM/IO bus
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int FETCH_BYTES = FETCH_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        in_lsb_ready,
  input  logic [2:0]  op_out,
  input  logic [6:0]  instr_type_out,
  input  logic [31:0] data_addr_out,
  input  logic [31:0] data_out,
  output logic        welcome_lsb,
  output logic        cache_ready,
  output logic [6:0]  cache_instr_type,
  output logic [31:0] cache_data_out,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data
);
  state_t state;
  logic [2:0] byte_cnt, n, op;
  logic [6:0] itype;
  logic [31:0] addr, data, raw, ext;
  logic [23:0] word;
  logic io, squash, cr_q, ir_q;
  assign welcome_lsb = state == IDLE && !rob_clear;
  assign cache_ready = cr_q && !rob_clear;
  assign if_ready = ir_q && !rob_clear;
  // bytes arrive LSB-first into the top of the shifter; right-align for short accesses
  assign raw = {mem_din, word} >> {3'd4 - n, 3'b000};
  mem_load_extend u_ext (.op(op), .raw(raw), .data(ext));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
      cr_q <= 1'b0;
      ir_q <= 1'b0;
      cache_instr_type <= '0;
      cache_data_out <= '0;
      if_data <= '0;
      byte_cnt <= '0;
      n <= '0;
      op <= '0;
      itype <= '0;
      addr <= '0;
      data <= '0;
      word <= '0;
      io <= 1'b0;
      squash <= 1'b0;
    end else if (rdy) begin
      cr_q <= 1'b0;
      ir_q <= 1'b0;
      mem_wr <= 1'b0;
      mem_a <= '0;
      mem_dout <= '0;
      case (state)
        IDLE: if (!rob_clear && (in_lsb_ready || if_req)) begin
          byte_cnt <= '0;
          word <= '0;
          squash <= 1'b0;
          if (in_lsb_ready) begin
            op <= op_out;
            itype <= instr_type_out;
            addr <= data_addr_out;
            data <= data_out;
            n <= width_of(op_out);
            io <= data_addr_out >= IO_BASE;
            if (instr_type_out == S_TYPE) begin
              state <= STORE;
              if (!(data_addr_out >= IO_BASE && io_buffer_full)) begin
                mem_wr <= 1'b1;
                mem_a <= data_addr_out;
                mem_dout <= data_out[7:0];
                byte_cnt <= 3'd1;
              end
            end else begin
              state <= LOAD;
              mem_a <= data_addr_out;
            end
          end else begin
            state <= FETCH;
            addr <= if_addr;
            n <= 3'(FETCH_BYTES);
            mem_a <= if_addr;
          end
        end
        LOAD, FETCH: if (rob_clear) state <= IDLE;
        else begin
          if (byte_cnt + 3'd1 < n) mem_a <= addr + 32'(byte_cnt) + 32'd1;
          if (byte_cnt != 3'd0) word <= {mem_din, word[23:8]};
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == n) begin
            state <= DONE;
            if (state == LOAD) begin
              cr_q <= 1'b1;
              cache_instr_type <= itype;
              cache_data_out <= ext;
            end else begin
              ir_q <= 1'b1;
              if_data <= raw;
            end
          end
        end
        STORE: begin
          if (rob_clear) squash <= 1'b1;
          // a flushed store still finishes writing; only its completion pulse is dropped
          if (byte_cnt == n) begin
            state <= (squash || rob_clear) ? IDLE : DONE;
            cr_q <= !(squash || rob_clear);
            cache_instr_type <= (squash || rob_clear) ? cache_instr_type : itype;
            cache_data_out <= (squash || rob_clear) ? cache_data_out : '0;
          end else if (!(io && io_buffer_full)) begin
            mem_wr <= 1'b1;
            mem_a <= addr + 32'(byte_cnt);
            mem_dout <= 8'(data >> {byte_cnt, 3'b000});
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a read-only byte RAM model
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  logic clk, rst, rdy, rob_clear, io_buffer_full, mem_wr, in_lsb_ready, welcome_lsb;
  logic cache_ready, if_req, if_ready;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a, data_addr_out, data_out, cache_data_out, if_addr, if_data;
  logic [2:0] op_out;
  logic [6:0] instr_type_out, cache_instr_type;
  logic [7:0] ram [0:4095];
  logic [31:0] wa [8];
  logic [7:0] wd [8];
  logic [31:0] trace [0:31];
  int nw, ncr, nir, checks, errors, cyc;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .in_lsb_ready(in_lsb_ready), .op_out(op_out), .instr_type_out(instr_type_out),
    .data_addr_out(data_addr_out), .data_out(data_out), .welcome_lsb(welcome_lsb),
    .cache_ready(cache_ready), .cache_instr_type(cache_instr_type), .cache_data_out(cache_data_out),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) mem_din <= ram[mem_a[11:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc_rec();
    @(negedge clk);
    if (mem_wr && nw < 8) begin
      wa[nw] = mem_a;
      wd[nw] = mem_dout;
      nw++;
    end
    if (cache_ready) ncr++;
    if (if_ready) nir++;
  endtask

  task automatic lsb(input logic [2:0] op, input logic [6:0] t, input logic [31:0] a, input logic [31:0] d);
    op_out = op;
    instr_type_out = t;
    data_addr_out = a;
    data_out = d;
    in_lsb_ready = 1'b1;
    nw = 0;
    ncr = 0;
    nir = 0;
  endtask

  task automatic wait_pulse(input bit f, output int c);
    c = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc_rec();
      trace[i] = mem_a;
      if (f ? if_ready : cache_ready) begin
        c = i;
        break;
      end
    end
    if (f) if_req = 1'b0;
    else in_lsb_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    rob_clear = 1'b0;
    io_buffer_full = 1'b0;
    in_lsb_ready = 1'b0;
    if_req = 1'b0;
    op_out = '0;
    instr_type_out = '0;
    data_addr_out = '0;
    data_out = '0;
    if_addr = '0;
    for (int i = 0; i < 32; i++) trace[i] = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h200] = 8'h80;
    ram[12'h210] = 8'h00; ram[12'h211] = 8'h80;
    ram[12'h500] = 8'h13;
    repeat (2) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_welcome", 32'(welcome_lsb), 32'h1);
    chk("rst_cache_ready", 32'(cache_ready), 32'h0);
    chk("rst_if_ready", 32'(if_ready), 32'h0);
    chk("rst_cache_data", cache_data_out, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    // LW little-endian assembly and latency
    lsb(F3_W, LD_TYPE, 32'h100, 32'h0);
    wait_pulse(1'b0, cyc);
    chk("lw_latency", 32'(cyc), 32'd6);
    chk("lw_data", cache_data_out, 32'h1234_5678);
    chk("lw_type", 32'(cache_instr_type), 32'(LD_TYPE));
    chk("lw_addr_b0", trace[1], 32'h100);
    chk("lw_addr_b3", trace[4], 32'h103);
    chk("lw_addr_idle", trace[5], 32'h0);
    @(negedge clk);
    lsb(F3_B, LD_TYPE, 32'h200, 32'h0);
    wait_pulse(1'b0, cyc);
    chk("lb_latency", 32'(cyc), 32'd3);
    chk("lb_data", cache_data_out, 32'hFFFF_FF80);
    @(negedge clk);
    lsb(F3_BU, LD_TYPE, 32'h200, 32'h0);
    wait_pulse(1'b0, cyc);
    chk("lbu_data", cache_data_out, 32'h0000_0080);
    @(negedge clk);
    lsb(F3_H, LD_TYPE, 32'h210, 32'h0);
    wait_pulse(1'b0, cyc);
    chk("lh_latency", 32'(cyc), 32'd4);
    chk("lh_data", cache_data_out, 32'hFFFF_8000);
    @(negedge clk);
    lsb(F3_HU, LD_TYPE, 32'h210, 32'h0);
    wait_pulse(1'b0, cyc);
    chk("lhu_data", cache_data_out, 32'h0000_8000);
    @(negedge clk);
    // SW byte serialisation
    lsb(F3_W, S_TYPE, 32'h400, 32'hDEAD_BEEF);
    wait_pulse(1'b0, cyc);
    chk("sw_latency", 32'(cyc), 32'd5);
    chk("sw_nwrites", 32'(nw), 32'd4);
    chk("sw_a0", wa[0], 32'h400);
    chk("sw_d0", 32'(wd[0]), 32'hEF);
    chk("sw_d1", 32'(wd[1]), 32'hBE);
    chk("sw_d2", 32'(wd[2]), 32'hAD);
    chk("sw_a3", wa[3], 32'h403);
    chk("sw_d3", 32'(wd[3]), 32'hDE);
    chk("sw_data_zero", cache_data_out, 32'h0);
    chk("sw_type", 32'(cache_instr_type), 32'(S_TYPE));
    @(negedge clk);
    // SB to IO with the write buffer full for three cycles
    lsb(F3_B, S_TYPE, 32'h0003_0000, 32'h0000_0041);
    io_buffer_full = 1'b1;
    repeat (3) cyc_rec();
    chk("io_held_writes", 32'(nw), 32'd0);
    chk("io_held_addr", mem_a, 32'h0);
    io_buffer_full = 1'b0;
    wait_pulse(1'b0, cyc);
    chk("io_nwrites", 32'(nw), 32'd1);
    chk("io_addr", wa[0], 32'h0003_0000);
    chk("io_data", 32'(wd[0]), 32'h41);
    chk("io_latency", 32'(cyc), 32'd2);
    @(negedge clk);
    // simultaneous LSB and fetch: LSB first, then fetch
    lsb(F3_W, LD_TYPE, 32'h100, 32'h0);
    if_addr = 32'h500;
    if_req = 1'b1;
    wait_pulse(1'b0, cyc);
    chk("arb_lsb_latency", 32'(cyc), 32'd6);
    chk("arb_no_if_yet", 32'(nir), 32'd0);
    wait_pulse(1'b1, cyc);
    chk("arb_fetch_latency", 32'(cyc), 32'd7);
    chk("arb_fetch_addr", trace[2], 32'h500);
    chk("arb_fetch_data", if_data, 32'h0000_0013);
    chk("arb_single_cr", 32'(ncr), 32'd1);
    @(negedge clk);
    // flush during fetch byte 2
    nir = 0;
    if_addr = 32'h500;
    if_req = 1'b1;
    repeat (3) cyc_rec();
    chk("flush_fetch_b2_addr", mem_a, 32'h502);
    rob_clear = 1'b1;
    cyc_rec();
    chk("flush_fetch_idle_addr", mem_a, 32'h0);
    rob_clear = 1'b0;
    if_req = 1'b0;
    cyc_rec();
    chk("flush_fetch_welcome", 32'(welcome_lsb), 32'h1);
    repeat (8) cyc_rec();
    chk("flush_fetch_no_ready", 32'(nir), 32'd0);
    // flush during SW byte 1: store completes silently
    lsb(F3_W, S_TYPE, 32'h600, 32'hCAFE_F00D);
    repeat (2) cyc_rec();
    rob_clear = 1'b1;
    in_lsb_ready = 1'b0;
    cyc_rec();
    rob_clear = 1'b0;
    repeat (8) cyc_rec();
    chk("flush_sw_nwrites", 32'(nw), 32'd4);
    chk("flush_sw_d1", 32'(wd[1]), 32'hF0);
    chk("flush_sw_a3", wa[3], 32'h603);
    chk("flush_sw_d3", 32'(wd[3]), 32'hCA);
    chk("flush_sw_no_ready", 32'(ncr), 32'd0);
    // asynchronous reset in the middle of a store
    lsb(F3_W, S_TYPE, 32'h700, 32'h1122_3344);
    cyc_rec();
    chk("rst_mid_wr_active", 32'(mem_wr), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", 32'(mem_wr), 32'h0);
    chk("rst_mid_addr", mem_a, 32'h0);
    chk("rst_mid_welcome", 32'(welcome_lsb), 32'h1);
    in_lsb_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
